// File: rtl/lsq_issue_arbiter.sv
// ---------------------------------------------------------------------------
// lsq_issue_arbiter
//
// Purpose:
//   Picks at most one memory operation per cycle. The candidates are the
//   oldest load from the load queue and the oldest released store from the
//   store queue. The chosen operation goes to its target memory sub-unit:
//   local mem, bus or dcache.
//   Loads normally win. A store is forced through in three cases:
//     - the store queue is full;
//     - the store has lost arbitration STARVE_LIMIT times in a row;
//     - a fence drain is in progress.
//   The block also sequences fences. After a fence request, loads are held
//   off until the store queue is empty and every sub-unit is idle. A single
//   fence_done pulse then marks the end of the drain.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   lq_valid           oldest load is ready to issue
//   lq_store_conflict  oldest load aliases an unissued store (blocked)
//   lq_subunit         target sub-unit index of the load
//   lq_pop             load issued this cycle
//   sq_valid           oldest store is valid and released
//   sq_subunit         target sub-unit index of the store
//   sq_full            store queue full (registered upstream)
//   sq_empty           store queue empty
//   sq_pop             store issued this cycle
//   sub_ready          per sub-unit: can accept a request this cycle
//   sub_idle           per sub-unit: nothing outstanding
//   sub_issue          one-hot request strobe to the selected sub-unit
//   sub_is_store       the issued request is a store
//   fence_req          single-cycle fence request
//   fence_busy         fence drain in progress
//   fence_done         single-cycle pulse when the drain completes
// ---------------------------------------------------------------------------
module lsq_issue_arbiter #(
    parameter int SUBUNITS     = 3,
    parameter int SUBUNIT_W    = (SUBUNITS > 1) ? $clog2(SUBUNITS) : 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lq_valid,
    input  logic                 lq_store_conflict,
    input  logic [SUBUNIT_W-1:0] lq_subunit,
    output logic                 lq_pop,
    input  logic                 sq_valid,
    input  logic [SUBUNIT_W-1:0] sq_subunit,
    input  logic                 sq_full,
    input  logic                 sq_empty,
    output logic                 sq_pop,
    input  logic [SUBUNITS-1:0]  sub_ready,
    input  logic [SUBUNITS-1:0]  sub_idle,
    output logic [SUBUNITS-1:0]  sub_issue,
    output logic                 sub_is_store,
    input  logic                 fence_req,
    output logic                 fence_busy,
    output logic                 fence_done
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;

    logic lq_target_ready;
    logic sq_target_ready;
    logic load_ok;
    logic store_ok;
    logic store_pri;
    logic grant_store;
    logic grant_load;
    logic drain_complete;

    // Look up the readiness of each candidate's target sub-unit. Comparing
    // the index against every real sub-unit handles indices past the last
    // sub-unit: they match nothing, so they read as not ready and are never
    // issued. No out-of-range vector index is ever formed.
    always_comb begin
        lq_target_ready = 1'b0;
        sq_target_ready = 1'b0;
        for (int i = 0; i < SUBUNITS; i++) begin
            if (lq_subunit == SUBUNIT_W'(i)) begin
                lq_target_ready = sub_ready[i];
            end
            if (sq_subunit == SUBUNIT_W'(i)) begin
                sq_target_ready = sub_ready[i];
            end
        end
    end

    // Same-cycle grant. Loads are only eligible in NORMAL. A store takes the
    // slot in two cases. The first is when it has priority: the queue is
    // full, it has been passed over too often, or a fence is draining. The
    // second is when no load can use the slot.
    always_comb begin
        load_ok     = lq_valid & ~lq_store_conflict & lq_target_ready &
                      (state == ST_NORMAL);
        store_ok    = sq_valid & sq_target_ready;
        store_pri   = sq_full | (starve_cnt == STARVE_MAX) |
                      (state != ST_NORMAL);
        grant_store = store_ok & (store_pri | ~load_ok);
        grant_load  = load_ok & ~grant_store;
    end

    // Drive the strobes for the granted operation. At most one grant is
    // active, so sub_issue ends up one-hot or all-zero.
    always_comb begin
        sq_pop       = grant_store;
        lq_pop       = grant_load;
        sub_is_store = grant_store;
        sub_issue    = '0;
        for (int i = 0; i < SUBUNITS; i++) begin
            sub_issue[i] = (grant_store & (sq_subunit == SUBUNIT_W'(i))) |
                           (grant_load  & (lq_subunit == SUBUNIT_W'(i)));
        end
    end

    // The drain ends once nothing store-related can still be in flight. The
    // queue must be empty, every sub-unit must be idle, and no store may be
    // leaving in this same cycle.
    always_comb begin
        drain_complete = sq_empty & (&sub_idle) & ~grant_store;
    end

    // Starvation counter. It counts cycles in which an eligible store lost
    // to a load, and saturates at the limit, where the store gets priority.
    // Issuing the store, or having no valid store, starts the count again.
    // In all other cases the count is held. A store blocked only by its
    // sub-unit's readiness therefore does not lose its progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_store | ~sq_valid) begin
            starve_cnt <= '0;
        end else if (store_ok & grant_load & (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Fence sequencer, with fence_busy and fence_done registered next to the
    // state. A fence request moves NORMAL to DRAIN. Any load granted in that
    // same cycle still issues, because the grant uses the current state.
    // DRAIN waits for the queue and sub-units to go quiet. DONE lasts exactly
    // one cycle and then returns to NORMAL. Fence requests outside NORMAL are
    // dropped; upstream holds them while fence_busy is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_NORMAL;
            fence_busy <= 1'b0;
            fence_done <= 1'b0;
        end else begin
            case (state)
                ST_NORMAL: begin
                    if (fence_req) begin
                        state      <= ST_DRAIN;
                        fence_busy <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_complete) begin
                        state      <= ST_DONE;
                        fence_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state      <= ST_NORMAL;
                    fence_busy <= 1'b0;
                    fence_done <= 1'b0;
                end
                default: begin
                    state      <= ST_NORMAL;
                    fence_busy <= 1'b0;
                    fence_done <= 1'b0;
                end
            endcase
        end
    end

    // Structural invariants of the issue port and the fence handshake.
    a_single_grant : assert property (@(posedge clk) disable iff (rst)
        !(lq_pop && sq_pop));
    a_onehot_issue : assert property (@(posedge clk) disable iff (rst)
        $onehot0(sub_issue));
    a_store_valid  : assert property (@(posedge clk) disable iff (rst)
        sq_pop |-> sq_valid);
    a_load_clean   : assert property (@(posedge clk) disable iff (rst)
        lq_pop |-> !lq_store_conflict);
    a_done_busy    : assert property (@(posedge clk) disable iff (rst)
        fence_done |-> $past(fence_busy));

endmodule
